buf_tx_send: RTL
================

Name: buf_tx_send

Overview:
- Consumer end of the packet buffer RAM filled by the FIFO-to-RAM framer.
- On `start`, latches channel, byte length and checksum, then reads the buffer RAM word by word.
- Emits a framed byte stream (header, payload, checksum trailer) over a valid/ready interface.
- Pulses `end_tx` when the frame is complete; the framer uses this pulse to arm its next buffer fill.

Parameters:
- N_BUF, 360: maximum payload words; larger requests are clamped.
- AW, 11: RAM address width.
- SYNC, 8'hA5: first header byte.

Ports:
- clk  in  1: system clock.
- rst  in  1: reset, asynchronous, active-low (0 = reset).
- start  in  1: one-cycle pulse, buffer ready.
- channel  in  8: source channel; valid with `start`.
- nbuf  in  16: payload length in bytes; valid with `start`.
- crc_buf  in  32: framer checksum; valid with `start`.
- rd_adr  out  AW: buffer RAM read address.
- rd_q  in  32: RAM read data; 1-cycle latency.
- tx_data  out  8: stream byte.
- tx_valid  out  1: byte valid.
- tx_ready  in  1: sink accepts byte.
- tx_last  out  1: final byte of frame.
- busy  out  1: high in any state except IDLE.
- end_tx  out  1: one-cycle pulse, frame done.
- crc_err  out  1: recomputed checksum differs from `crc_buf`.

Behaviour:
- Reset (`rst`=0, takes effect immediately, no clock needed):
  - State goes to IDLE.
  - All outputs go to 0, including `rd_adr`.
  - Latched fields, word counter and accumulator clear.
  - Reset mid-frame abandons the frame; no `end_tx` is issued.
- Byte transfer: a byte moves on a clk edge when `tx_valid`=1 and `tx_ready`=1.
  - `tx_data` and `tx_last` hold stable while `tx_valid`=1 and `tx_ready`=0.
- Word count: WN = `nbuf`[15:2], clamped to N_BUF. `nbuf`[1:0] is ignored.
- Frame byte order:
  - Header: SYNC, channel, nbuf[15:8], nbuf[7:0]. The latched `nbuf` is sent unmodified.
  - Payload: each word MSB byte first ([31:24] ... [7:0]).
  - Trailer: `crc_buf`[31:24] ... [7:0].
- State machine:
  - IDLE: on `start`=1, latch `channel`, `nbuf`, `crc_buf`; clear word index and accumulator; go to HDR. `start` is ignored in every other state.
  - HDR: 4 bytes. After the 4th accept, go to FETCH if WN>0, else TRL.
  - FETCH: drive `rd_adr` = word index (starting at 0); `tx_valid`=0; go to LOAD.
  - LOAD: capture `rd_q` into the shift register; accumulate checksum; increment word index; go to PAY.
  - PAY: 4 bytes from the shift register. After the 4th accept, go to FETCH if index < WN, else TRL.
  - TRL: 4 bytes; `tx_last`=1 on the 4th. After the 4th accept, go to DONE.
  - DONE: `end_tx`=1 for exactly 1 cycle; `crc_err` updated; go to IDLE.
- Checksum: acc <= acc + rd_q[31:16] + rd_q[15:0], 32-bit unsigned, wraps modulo 2^32.
  - In DONE: `crc_err` = (acc != latched `crc_buf`).
  - `crc_err` holds its value until the next accepted `start`, which clears it.
- Timing:
  - `busy` is 1 from the cycle after the accepted `start` through DONE.
  - With `tx_ready` tied to 1, `end_tx` occurs 9 + 6*WN cycles after the `start` cycle.
  - Each word costs a 2-cycle bubble (FETCH, LOAD).
- `rd_adr` holds its last value outside FETCH.

Optional Feature:
- TX_CRC_CHECK_EN defined: accumulator and compare are built as described above.
- TX_CRC_CHECK_EN undefined: no accumulator; `crc_err` is constant 0. The trailer still carries the latched `crc_buf` unmodified. Frame timing is identical.

Test Plan:
- RAM[0]=0x00010002, RAM[1]=0x00030004; `start` with nbuf=8, channel=1, crc_buf=0x0000000A; `tx_ready`=1 -> bytes A5 01 00 08 00 01 00 02 00 03 00 04 00 00 00 0A; `tx_last` on the final byte; `end_tx` 21 cycles after `start`; `crc_err`=0.
- Same frame with crc_buf=0x0000000B -> identical byte stream; `crc_err`=1 after `end_tx`; next `start` clears `crc_err`.
- `tx_ready` toggles 1,0,1,0 throughout -> identical byte sequence; `tx_data` stable during every stall; exactly one `end_tx`.
- nbuf=0, crc_buf=0 -> 8 bytes only (A5 ch 00 00 00 00 00 00); no FETCH cycles; `crc_err`=0.
- nbuf=2000 (500 words) -> header carries 07 D0; exactly 360 payload words read, `rd_adr` 0..359; `end_tx` once.
- Second `start` during PAY -> ignored, frame unchanged. `rst`=0 mid-PAY -> all outputs 0 immediately, no `end_tx`; a fresh `start` after release sends a complete frame.

Source files
------------

// File: rtl/buf_tx_send.sv
// ============================================================================
// Module   : buf_tx_send
// Purpose  : Reads a filled packet buffer RAM and sends it as a framed byte
//            stream over valid/ready: a 4-byte header (SYNC, channel,
//            nbuf[15:8], nbuf[7:0]), then the payload words MSB byte first,
//            then a 4-byte checksum trailer. end_tx pulses once the frame
//            is complete.
// Options  : TX_CRC_CHECK_EN - when defined, the payload is summed and
//            compared with crc_buf, and the result drives crc_err. When not
//            defined, crc_err is tied to 0.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module buf_tx_send #(
  parameter int          N_BUF = 360,
  parameter int          AW    = 11,
  parameter logic [7:0]  SYNC  = 8'hA5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [7:0]    channel,
  input  logic [15:0]   nbuf,
  input  logic [31:0]   crc_buf,
  output logic [AW-1:0] rd_adr,
  input  logic [31:0]   rd_q,
  output logic [7:0]    tx_data,
  output logic          tx_valid,
  input  logic          tx_ready,
  output logic          tx_last,
  output logic          busy,
  output logic          end_tx,
  output logic          crc_err
);

  localparam logic [13:0] NB_MAX = 14'(N_BUF);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HDR   = 3'd1,
    S_FETCH = 3'd2,
    S_LOAD  = 3'd3,
    S_PAY   = 3'd4,
    S_TRL   = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  state_t      state;
  logic [31:0] shreg;     // bytes still to send in the current 4-byte group
  logic [1:0]  bcnt;      // byte position within the current group
  logic [13:0] wn;        // clamped payload word count
  logic [13:0] widx;      // next word to fetch
  logic [31:0] crc_lat;   // trailer value, sent unmodified
  logic [13:0] wn_in;
  logic        xfer;

`ifdef TX_CRC_CHECK_EN
  logic [31:0] acc;
  logic        crc_err_q;
  assign crc_err = crc_err_q;
`else
  assign crc_err = 1'b0;
`endif

  // Requested word count, clamped to the buffer size.
  assign wn_in   = (nbuf[15:2] > NB_MAX) ? NB_MAX : nbuf[15:2];
  assign xfer    = tx_valid & tx_ready;
  // The top of the shift register is the byte on the bus, so it holds
  // while stalled.
  assign tx_data = shreg[31:24];

  // Frame sequencer; all outputs are registered here.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      shreg    <= 32'd0;
      bcnt     <= 2'd0;
      wn       <= 14'd0;
      widx     <= 14'd0;
      crc_lat  <= 32'd0;
      rd_adr   <= '0;
      tx_valid <= 1'b0;
      tx_last  <= 1'b0;
      busy     <= 1'b0;
      end_tx   <= 1'b0;
`ifdef TX_CRC_CHECK_EN
      acc       <= 32'd0;
      crc_err_q <= 1'b0;
`endif
    end else begin
      end_tx <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            shreg    <= {SYNC, channel, nbuf};
            wn       <= wn_in;
            crc_lat  <= crc_buf;
            widx     <= 14'd0;
            bcnt     <= 2'd0;
            tx_valid <= 1'b1;
            tx_last  <= 1'b0;
            busy     <= 1'b1;
            state    <= S_HDR;
`ifdef TX_CRC_CHECK_EN
            acc       <= 32'd0;
            crc_err_q <= 1'b0;
`endif
          end
        end
        S_HDR, S_PAY, S_TRL: begin
          if (xfer) begin
            shreg <= {shreg[23:0], 8'h00};
            bcnt  <= bcnt + 2'd1;
            if (state == S_TRL && bcnt == 2'd2) begin
              tx_last <= 1'b1;
            end
            if (bcnt == 2'd3) begin
              bcnt <= 2'd0;
              if (state == S_TRL) begin
                tx_valid <= 1'b0;
                tx_last  <= 1'b0;
                end_tx   <= 1'b1;
                state    <= S_DONE;
`ifdef TX_CRC_CHECK_EN
                crc_err_q <= (acc != crc_lat);
`endif
              end else if (widx < wn) begin
                // Word index is 0 after the header, so this covers both the
                // first fetch and each following one.
                tx_valid <= 1'b0;
                rd_adr   <= widx[AW-1:0];
                state    <= S_FETCH;
              end else begin
                shreg <= crc_lat;
                state <= S_TRL;
              end
            end
          end
        end
        S_FETCH: begin
          state <= S_LOAD;
        end
        S_LOAD: begin
          shreg    <= rd_q;
          widx     <= widx + 14'd1;
          tx_valid <= 1'b1;
          state    <= S_PAY;
`ifdef TX_CRC_CHECK_EN
          acc <= acc + 32'(rd_q[31:16]) + 32'(rd_q[15:0]);
`endif
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
